// File: rtl/lfsr_range_gen_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_range_gen_pkg
//   Shared definitions for the LFSR-based random blocks:
//   - draw FSM state encoding (IDLE / DRAW)
//   - clog2 helper usable in constant (parameter) expressions
//   - default maximal-length Galois feedback masks per LFSR width
// -----------------------------------------------------------------------------
package lfsr_range_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } draw_state_t;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Maximal-length Galois masks (taps applied when the shifted-out bit is 1).
  localparam logic [2:0]  TAPS_W3  = 3'b110;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

endpackage : lfsr_range_gen_pkg

// File: rtl/lfsr_galois.sv
// -----------------------------------------------------------------------------
// lfsr_galois
//   Free-running right-shifting Galois LFSR with synchronous load and a
//   zero guard, shared by the random-number blocks of the game.
//
//   Ports:
//     clk       in   1      clock, all state on posedge
//     reset     in   1      synchronous, active-high; q <= SEED
//     load      in   1      load load_val this cycle instead of stepping
//     load_val  in   WIDTH  value to load; 0 is replaced by SEED
//     q         out  WIDTH  current LFSR state (never 0)
// -----------------------------------------------------------------------------
module lfsr_galois
  import lfsr_range_gen_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W16),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  // All-zeros is the lock-up state of an XOR LFSR; a zero load falls back to
  // SEED so that state can never be entered.
  logic [WIDTH-1:0] load_safe;
  assign load_safe = (load_val == '0) ? SEED : load_val;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
    end else if (load) begin
      q <= load_safe;
    end else if (q[0]) begin
      q <= (q >> 1) ^ TAPS;
    end else begin
      q <= q >> 1;
    end
  end

endmodule : lfsr_galois

// File: rtl/lfsr_range_gen.sv
// -----------------------------------------------------------------------------
// lfsr_range_gen
//   Pseudo-random target generator for the bowling game. On a request the
//   low K bits of a free-running LFSR are rejection-sampled into 1..RANGE_MAX;
//   after MAX_TRIES rejected candidates a modulo fallback forces a result.
//   With NO_REPEAT set, a value equal to the previous delivery is rejected
//   (and the fallback is bumped to the next value in the range).
//
//   Ports:
//     clk        in   1      clock
//     reset      in   1      synchronous, active-high; aborts any draw
//     seed_load  in   1      reload LFSR from seed_in this cycle
//     seed_in    in   WIDTH  new seed; 0 substitutes SEED
//     req        in   1      draw request, accepted only when idle
//     busy       out  1      draw in progress
//     valid      out  1      one-cycle pulse: value updated this cycle
//     value      out  OUT_W  last delivered target (0 after reset)
//     lfsr_q     out  WIDTH  LFSR state, for verification/debug
// -----------------------------------------------------------------------------
module lfsr_range_gen
  import lfsr_range_gen_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_W16),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter int               RANGE_MAX = 4,
  parameter int               OUT_W     = 3,
  parameter int               MAX_TRIES = 8,
  parameter bit               NO_REPEAT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic [WIDTH-1:0] lfsr_q
);

  // Candidate width: enough bits to cover 0..RANGE_MAX-1.
  localparam int K     = (RANGE_MAX <= 1) ? 1 : clog2(RANGE_MAX);
  localparam int TRY_W = (MAX_TRIES <= 1) ? 1 : clog2(MAX_TRIES);

  // Datapath runs one bit wider than the output so cand+1 and the fallback
  // cannot wrap when RANGE_MAX == 2^OUT_W - 1.
  localparam logic [OUT_W:0]   RMAX     = (OUT_W + 1)'(RANGE_MAX);
  localparam logic [OUT_W:0]   ONE      = (OUT_W + 1)'(1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam bit               NR_ON    = NO_REPEAT && (RANGE_MAX > 1);

  draw_state_t      state;
  logic [TRY_W-1:0] tries;

  logic [OUT_W:0] cand;
  logic [OUT_W:0] cand_p1;
  logic [OUT_W:0] last_w;
  logic [OUT_W:0] forced;
  logic [OUT_W:0] forced_alt;
  logic [OUT_W:0] pick;
  logic           ok;
  logic           deliver;
  logic           unused_pick_msb;

  lfsr_galois #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (seed_in),
    .q        (lfsr_q)
  );

  // The delivered value doubles as the "last" register used by no-repeat:
  // both reset to 0 and are only ever updated together.
  assign last_w = {1'b0, value};

  // NOTE: every signal assigned in this always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand          = '0;
    cand[K-1:0]   = lfsr_q[K-1:0];
    cand_p1       = cand + ONE;
    ok            = (cand < RMAX) && !(NR_ON && (cand_p1 == last_w));
    forced        = (cand % RMAX) + ONE;
    forced_alt    = (forced % RMAX) + ONE;
    pick          = forced;
    if (ok) begin
      pick = cand_p1;
    end else if (NR_ON && (forced == last_w)) begin
      pick = forced_alt;
    end
    deliver = ok || (tries == LAST_TRY);
  end

  // pick never exceeds RANGE_MAX, which fits in OUT_W bits.
  assign unused_pick_msb = pick[OUT_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      value <= '0;
      tries <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // A request arriving in the delivery cycle is dropped, not queued.
          if (req && !valid) begin
            state <= ST_DRAW;
            tries <= '0;
            busy  <= 1'b1;
          end
        end
        ST_DRAW: begin
          if (deliver) begin
            value <= pick[OUT_W-1:0];
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            // The LFSR steps every cycle, so the next candidate is fresh.
            tries <= tries + TRY_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : lfsr_range_gen

// File: tb/tb_lfsr_range_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_range_gen
//   Three generator configurations share one stimulus stream:
//     u0: defaults (RANGE_MAX=4, MAX_TRIES=8, NO_REPEAT=0)
//     u1: RANGE_MAX=3, MAX_TRIES=1, NO_REPEAT=1
//     u2: RANGE_MAX=5, MAX_TRIES=3, NO_REPEAT=1 (exercises rejection)
//   A reference model predicts each accepted draw (value and delivery cycle)
//   into a per-instance queue; a monitor pops and compares on every valid.
// -----------------------------------------------------------------------------
module tb_lfsr_range_gen;

  localparam int N = 3;
  localparam int RM[N] = '{4, 3, 5};
  localparam int KB[N] = '{2, 2, 3};
  localparam int MT[N] = '{8, 1, 3};
  localparam int NR[N] = '{0, 1, 1};

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        req;

  logic        busy   [N];
  logic        valid  [N];
  logic [2:0]  value  [N];
  logic [15:0] lfsr_q [N];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int phase    = 0;
  int hist [5];

  // Model state per instance.
  logic [15:0] m_lfsr  [N];
  int          ok_from [N];
  int          bf      [N];
  int          bt      [N];
  int          m_last  [N];
  int          held    [N];
  exp_t        sb      [N][$];

  always #5 clk = ~clk;

  lfsr_range_gen u0 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .busy(busy[0]), .valid(valid[0]), .value(value[0]), .lfsr_q(lfsr_q[0])
  );

  lfsr_range_gen #(.RANGE_MAX(3), .MAX_TRIES(1), .NO_REPEAT(1'b1)) u1 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .busy(busy[1]), .valid(valid[1]), .value(value[1]), .lfsr_q(lfsr_q[1])
  );

  lfsr_range_gen #(.RANGE_MAX(5), .MAX_TRIES(3), .NO_REPEAT(1'b1)) u2 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .busy(busy[2]), .valid(valid[2]), .value(value[2]), .lfsr_q(lfsr_q[2])
  );

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endtask

  function automatic logic [15:0] step16(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // One draw as the rules describe it: starting from the LFSR state seen in
  // the first DRAW cycle, try successive states until one is acceptable or
  // the attempts run out. Returns the value and the number of DRAW cycles.
  function automatic void plan(input logic [15:0] s0, input int rm, input int k,
                               input int mt, input int nr, input int last,
                               output int val, output int ncyc);
    logic [15:0] s;
    int cand;
    int f;
    s    = s0;
    val  = 0;
    ncyc = mt;
    for (int t = 0; t < mt; t++) begin
      cand = int'(s) % (1 << k);
      if (cand < rm && !(nr != 0 && rm > 1 && cand + 1 == last)) begin
        val  = cand + 1;
        ncyc = t + 1;
        return;
      end
      if (t == mt - 1) begin
        f = (cand % rm) + 1;
        if (nr != 0 && f == last) f = (f % rm) + 1;
        val  = f;
        ncyc = t + 1;
        return;
      end
      s = step16(s);
    end
  endfunction

  // Reference model: advances on every rising edge using the inputs the
  // stimulus applied half a cycle earlier.
  initial begin
    logic [15:0] nxt;
    int v;
    int n;
    for (int i = 0; i < N; i++) begin
      m_lfsr[i] = 16'h0001; ok_from[i] = 0; bf[i] = 0; bt[i] = 0;
      m_last[i] = 0; held[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (reset) begin
          m_lfsr[i] = 16'h0001; ok_from[i] = 0; bf[i] = 0; bt[i] = 0;
          m_last[i] = 0; held[i] = 0;
          sb[i].delete();
        end else begin
          nxt = seed_load ? ((seed_in == 16'h0) ? 16'h0001 : seed_in) : step16(m_lfsr[i]);
          if (sb[i].size() > 0 && sb[i][0].due == cyc) held[i] = sb[i][0].val;
          if (req && cyc >= ok_from[i]) begin
            plan(nxt, RM[i], KB[i], MT[i], NR[i], m_last[i], v, n);
            sb[i].push_back('{val: v, due: cyc + n});
            bf[i]      = cyc;
            bt[i]      = cyc + n;
            ok_from[i] = cyc + n + 2;
            m_last[i]  = v;
          end
          m_lfsr[i] = nxt;
        end
      end
    end
  end

  // Monitor: compares DUT outputs on the falling edge.
  initial begin
    exp_t e;
    logic [2:0] prev [N];
    for (int i = 0; i < N; i++) prev[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        while (sb[i].size() > 0 && sb[i][0].due < cyc) begin
          e = sb[i].pop_front();
          check($sformatf("u%0d draw timeout (due cycle)", i), cyc, e.due);
        end
        if (valid[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("u%0d unexpected valid", i), 1, 0);
          end else begin
            e = sb[i].pop_front();
            check($sformatf("u%0d draw value", i), value[i], e.val);
            check($sformatf("u%0d draw latency", i), cyc, e.due);
          end
          check($sformatf("u%0d value in range", i),
                (value[i] >= 1 && value[i] <= RM[i]), 1);
          if (NR[i] != 0) check($sformatf("u%0d no repeat", i), (value[i] != prev[i]), 1);
          if (phase == 3 && i == 0 && value[0] <= 3'd4) hist[value[0]]++;
        end
        check($sformatf("u%0d held value", i), value[i], held[i]);
        check($sformatf("u%0d busy", i), busy[i], (cyc >= bf[i] && cyc < bt[i]));
        check($sformatf("u%0d lfsr_q", i), lfsr_q[i], m_lfsr[i]);
        prev[i] = value[i];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int first_ret;
    int zero_seen;
    int total;

    // Reset held for three edges with req asserted.
    reset = 1'b1; req = 1'b1; seed_load = 1'b0; seed_in = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d reset busy", i), busy[i], 0);
      check($sformatf("u%0d reset valid", i), valid[i], 0);
      check($sformatf("u%0d reset value", i), value[i], 0);
      check($sformatf("u%0d reset lfsr", i), lfsr_q[i], 16'h0001);
    end
    reset = 1'b0;
    @(negedge clk);
    req = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      cnt += int'(valid[0]);
    end
    check("single req one valid pulse", cnt, 1);

    // Full period from seed 1.
    seed_load = 1'b1; seed_in = 16'h0001;
    @(negedge clk);
    seed_load = 1'b0;
    first_ret = 0; zero_seen = 0;
    for (int c = 1; c <= 65535; c++) begin
      @(negedge clk);
      if (lfsr_q[0] == 16'h0) zero_seen = 1;
      if (lfsr_q[0] == 16'h0001 && first_ret == 0) first_ret = c;
    end
    check("lfsr period", first_ret, 65535);
    check("lfsr zero state seen", zero_seen, 0);

    // Random-gap requests: distribution on u0, rejection/no-repeat on u1/u2.
    for (int v = 0; v < 5; v++) hist[v] = 0;
    phase = 3;
    repeat (2000) begin
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    phase = 0;
    total = hist[1] + hist[2] + hist[3] + hist[4];
    check("distribution sample size ok", (total >= 800), 1);
    check("distribution no zero", hist[0], 0);
    for (int v = 1; v <= 4; v++)
      check($sformatf("distribution bin %0d within 20..30%%", v),
            (hist[v] * 10 >= total * 2 && hist[v] * 10 <= total * 3), 1);

    // Seed load and zero guard.
    seed_load = 1'b1; seed_in = 16'h0000;
    @(negedge clk);
    check("seed 0 -> SEED", lfsr_q[0], 16'h0001);
    seed_in = 16'hACE1;
    @(negedge clk);
    seed_load = 1'b0;
    check("seed ACE1 loaded", lfsr_q[0], 16'hACE1);
    @(negedge clk);
    check("step after ACE1", lfsr_q[0], 16'hE270);

    // Reset one cycle after a request aborts the draw.
    repeat (4) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d abort busy", i), busy[i], 0);
      check($sformatf("u%0d abort value", i), value[i], 0);
    end
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) cnt += int'(valid[i]);
    end
    check("no valid after abort", cnt, 0);

    // Back-to-back requests: extra ones are dropped, latency checked by model.
    req = 1'b1;
    repeat (50) @(negedge clk);
    req = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("u%0d scoreboard drained", i), sb[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lfsr_range_gen
